tt_um_uart_rx: RTL and testbench

TT_UM_UART_RX -- requirements
Module: tt_um_uart_rx

---
 rtl/tt_um_uart_rx.sv | 146 ++++++++++++++
 tb/tb_tt_um_uart_rx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tt_um_uart_rx.sv
// UART 8N1 receiver with a 4-entry byte FIFO, sticky error flags and status byte.
// Head byte on uo_out; status on uio_out (uio always driven).
module tt_um_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;

    logic r_rx_s1, r_rx_s2, r_pop_s1, r_pop_s2, r_pop_prev, r_clr_s1, r_clr_s2;
    logic r_ovr, r_ferr;

    logic [7:0] r_mem [4];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count;

    logic w_rx, w_bit_done, w_push, w_ferr_set, w_pop_edge;
    logic w_full, w_do_pop, w_do_push, w_ovr_set;
    logic w_unused;

    assign w_unused = ^{ena, uio_in, ui_in[7:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_pop_s1   <= 1'b0;
            r_pop_s2   <= 1'b0;
            r_pop_prev <= 1'b0;
            r_clr_s1   <= 1'b0;
            r_clr_s2   <= 1'b0;
        end else begin
            r_rx_s1    <= ui_in[0];
            r_rx_s2    <= r_rx_s1;
            r_pop_s1   <= ui_in[1];
            r_pop_s2   <= r_pop_s1;
            r_pop_prev <= r_pop_s2;
            r_clr_s1   <= ui_in[2];
            r_clr_s2   <= r_clr_s1;
        end
    end

    assign w_rx       = r_rx_s2;
    assign w_bit_done = (r_timer == FULL_T);
    assign w_push     = (r_state == StStop) && w_bit_done && w_rx;
    assign w_ferr_set = (r_state == StStop) && w_bit_done && !w_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_timer <= '0;
                    if (!w_rx) r_state <= StStart;
                end
                StStart: begin
                    // Mid-start-bit check rejects short low glitches.
                    if (r_timer == HALF_T) begin
                        r_timer <= '0;
                        r_idx   <= 3'd0;
                        r_state <= w_rx ? StIdle : StData;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StData: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= StStop;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StStop: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= w_rx ? StIdle : StWaitHigh;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StWaitHigh: begin
                    if (w_rx) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_pop_edge = r_pop_s2 && !r_pop_prev;
    assign w_full     = (r_count == 3'd4);
    assign w_do_pop   = w_pop_edge && (r_count != 3'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push  = w_push && (!w_full || w_do_pop);
    assign w_ovr_set  = w_push && w_full && !w_do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_do_pop) r_rptr <= r_rptr + 2'd1;
            r_count <= r_count + {2'b00, w_do_push} - {2'b00, w_do_pop};
            if (w_ovr_set)     r_ovr <= 1'b1;
            else if (r_clr_s2) r_ovr <= 1'b0;
            if (w_ferr_set)    r_ferr <= 1'b1;
            else if (r_clr_s2) r_ferr <= 1'b0;
        end
    end

    assign uo_out  = (r_count == 3'd0) ? 8'h00 : r_mem[r_rptr];
    assign uio_out = {r_count, (r_state != StIdle), r_ferr, r_ovr, w_full, (r_count != 3'd0)};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uart_rx.sv
// Directed bench for tt_um_uart_rx: frames, FIFO fill/overrun, framing error, glitch, reset.
module tb_tt_um_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    tt_um_uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    // One frame, one bit per 16 negedges; optional pop pulse at index pop_at,
    // optional early abort at index stop_at (both -1 when unused).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int pop_at, input int stop_at);
        int slot;
        for (int i = 0; i < 160; i++) begin
            if (i == stop_at) return;
            slot = i / 16;
            if (slot == 0)      ui_in[0] = 1'b0;
            else if (slot == 9) ui_in[0] = stop_bit;
            else                ui_in[0] = data[slot-1];
            if (i == pop_at)     ui_in[1] = 1'b1;
            if (i == pop_at + 4) ui_in[1] = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pop();
        ui_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        ui_in[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_errs();
        ui_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h01;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("reset_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame
        send_frame(8'hA5, 1'b1, -1, -1);
        chk("a5_uo", uo_out, 8'hA5);
        chk("a5_uio", uio_out, 8'h21);
        pop();
        chk("a5_pop_uo", uo_out, 8'h00);
        chk("a5_pop_uio", uio_out, 8'h00);

        // Start-bit glitch
        ui_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        ui_in[0] = 1'b1;
        chk("glitch_busy", uio_out, 8'h10);
        repeat (20) @(negedge clk);
        chk("glitch_idle", uio_out, 8'h00);

        // Framing error: line held low through the stop bit
        send_frame(8'h3C, 1'b0, -1, -1);
        chk("ferr_uio", uio_out, 8'h18);
        chk("ferr_uo", uo_out, 8'h00);
        ui_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("ferr_idle", uio_out, 8'h08);
        clear_errs();
        chk("ferr_clr", uio_out, 8'h00);

        // Fill and overrun
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, -1, -1);
        chk("full_uio", uio_out, 8'h83);
        chk("full_uo", uo_out, 8'h01);
        send_frame(8'h05, 1'b1, -1, -1);
        chk("ovr_uio", uio_out, 8'h87);
        chk("ovr_uo", uo_out, 8'h01);
        for (int b = 1; b <= 4; b++) begin
            chk("drain_head", uo_out, 8'(b));
            pop();
        end
        chk("drain_uo", uo_out, 8'h00);
        chk("drain_uio", uio_out, 8'h04);
        pop();
        chk("empty_pop_uio", uio_out, 8'h04);
        clear_errs();
        chk("ovr_clr", uio_out, 8'h00);

        // Pop edge lands on the cycle of the fifth push
        for (int b = 0; b < 4; b++) send_frame(8'(8'h11 + b), 1'b1, -1, -1);
        chk("full2_uio", uio_out, 8'h83);
        send_frame(8'h15, 1'b1, 152, -1);
        chk("pp_uio", uio_out, 8'h83);
        for (int b = 0; b < 4; b++) begin
            chk("pp_head", uo_out, 8'(8'h12 + b));
            pop();
        end
        chk("pp_empty", uio_out, 8'h00);

        // Reset during data bit 3
        send_frame(8'h77, 1'b1, -1, -1);
        chk("pre_uo", uo_out, 8'h77);
        send_frame(8'h5A, 1'b1, -1, 72);
        chk("midframe_uio", uio_out, 8'h31);
        rst_n = 1'b0;
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);
        ui_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_uio", uio_out, 8'h00);
        send_frame(8'h5A, 1'b1, -1, -1);
        chk("post_rst_uo", uo_out, 8'h5A);
        chk("post_rst_status", uio_out, 8'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
